// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared block geometry, pixel layout and read-side FSM states for the JPEG front end.
package jpeg_pkg;
    localparam int BLOCK_DIM    = 8;
    localparam int BLOCK_PIXELS = 64;
    localparam int PIX_W        = 8;
    typedef struct packed {
        logic [PIX_W-1:0] cr;
        logic [PIX_W-1:0] cb;
        logic [PIX_W-1:0] y;
    } ycc_pixel_t;
    typedef enum logic {IDLE, SEND} rd_state_e;
endpackage

// File: rtl/ycc_block_bank.sv
// ycc_block_bank: one 8x8 block of {cr, cb, y} words, pixel-wide write port and row-wide read port.
module ycc_block_bank
    import jpeg_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [5:0]                 waddr,
    input  logic [3*W-1:0]             wdata,
    input  logic [2:0]                 row,
    output logic [BLOCK_DIM*3*W-1:0]   rdata
);
    logic [3*W-1:0] mem [BLOCK_PIXELS];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    for (genvar c = 0; c < BLOCK_DIM; c++) begin : g_col
        assign rdata[c*3*W +: 3*W] = mem[{row, 3'(c)}];
    end
endmodule

// File: rtl/ycc_block_buffer.sv
// ycc_block_buffer: ping-pong 8x8 block buffer between colour converter and DCT,
// level-shifting samples and handing out one row per valid/ready handshake.
module ycc_block_buffer
    import jpeg_pkg::*;
#(
    parameter int SAMPLE_W    = 8,
    parameter bit LEVEL_SHIFT = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [3*SAMPLE_W-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2:0]              out_row,
    output logic                    out_last,
    output logic [8*SAMPLE_W-1:0]   out_y,
    output logic [8*SAMPLE_W-1:0]   out_cb,
    output logic [8*SAMPLE_W-1:0]   out_cr,
    output logic                    overflow,
    input  logic                    ovf_clr
);
    localparam int PW = 3*SAMPLE_W;
    localparam logic [SAMPLE_W-1:0] FLIP = LEVEL_SHIFT ? {1'b1, {(SAMPLE_W-1){1'b0}}} : '0;

    rd_state_e state, state_n;
    logic wr_bank, rd_bank, hs, rel, accept, drop, set_full;
    logic [5:0] wr_cnt;
    logic [2:0] rd_row;
    logic [1:0] full, full_n;
    logic [BLOCK_DIM*PW-1:0] row0, row1, row_data;

    assign hs       = (state == SEND) && out_ready;
    assign rel      = hs && (rd_row == 3'd7);
    // a bank being released on this edge may take the next pixel on the same edge
    assign accept   = in_valid && (!full[wr_bank] || (rel && (rd_bank == wr_bank)));
    assign drop     = in_valid && !accept;
    assign set_full = accept && (wr_cnt == 6'd63);

    // next state looks at the post-edge full flags so no bubble appears between blocks
    always_comb begin
        full_n = full;
        if (rel) full_n[rd_bank] = 1'b0;
        if (set_full) full_n[wr_bank] = 1'b1;
        state_n = full_n[rd_bank ^ rel] ? SEND : IDLE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_cnt   <= '0;
            rd_row   <= '0;
            full     <= '0;
            overflow <= 1'b0;
        end else begin
            full     <= full_n;
            overflow <= drop | (overflow & ~ovf_clr);
            if (accept) wr_cnt <= wr_cnt + 6'd1;
            if (set_full) wr_bank <= ~wr_bank;
            if (hs) rd_row <= rd_row + 3'd1;
            if (rel) rd_bank <= ~rd_bank;
        end

    ycc_block_bank #(.W(SAMPLE_W)) u_bank0 (
        .clk(clk), .we(accept && !wr_bank), .waddr(wr_cnt), .wdata(in_data),
        .row(rd_row), .rdata(row0)
    );
    ycc_block_bank #(.W(SAMPLE_W)) u_bank1 (
        .clk(clk), .we(accept && wr_bank), .waddr(wr_cnt), .wdata(in_data),
        .row(rd_row), .rdata(row1)
    );

    assign row_data  = rd_bank ? row1 : row0;
    assign out_valid = (state == SEND);
    assign out_row   = rd_row;
    assign out_last  = out_valid && (rd_row == 3'd7);

    for (genvar c = 0; c < BLOCK_DIM; c++) begin : g_lane
        assign out_y[c*SAMPLE_W +: SAMPLE_W]  = out_valid ? row_data[c*PW +: SAMPLE_W] ^ FLIP : '0;
        assign out_cb[c*SAMPLE_W +: SAMPLE_W] = out_valid ? row_data[c*PW+SAMPLE_W +: SAMPLE_W] ^ FLIP : '0;
        assign out_cr[c*SAMPLE_W +: SAMPLE_W] = out_valid ? row_data[c*PW+2*SAMPLE_W +: SAMPLE_W] ^ FLIP : '0;
    end
endmodule

// File: tb/tb_ycc_block_buffer.sv
// tb_ycc_block_buffer: directed checks of the ping-pong block buffer, shifted and unshifted builds side by side.
module tb_ycc_block_buffer;
    logic clk, rst, in_valid, out_ready, ovf_clr;
    logic [23:0] in_data;
    logic v1, l1, o1, v2, l2, o2;
    logic [2:0] r1, r2;
    logic [63:0] y1, cb1, cr1, y2, cb2, cr2;
    int tests = 0, fails = 0;

    ycc_block_buffer #(.SAMPLE_W(8), .LEVEL_SHIFT(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(v1), .out_ready(out_ready), .out_row(r1), .out_last(l1),
        .out_y(y1), .out_cb(cb1), .out_cr(cr1), .overflow(o1), .ovf_clr(ovf_clr)
    );
    ycc_block_buffer #(.SAMPLE_W(8), .LEVEL_SHIFT(1'b0)) dut_raw (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(v2), .out_ready(out_ready), .out_row(r2), .out_last(l2),
        .out_y(y2), .out_cb(cb2), .out_cr(cr2), .overflow(o2), .ovf_clr(ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] lv(input int i);
        return (i == 0) ? 8'h00 : (i == 1) ? 8'h80 : 8'hFF;
    endfunction

    // block 0: Y=k, Cb=128, Cr=255; block 9: only 0/128/255; others: distinct per block
    function automatic logic [23:0] pix(input int b, input int k);
        if (b == 0) return {8'hFF, 8'h80, 8'(k)};
        if (b == 9) return {lv((k + 2) % 3), lv((k + 1) % 3), lv(k % 3)};
        return {8'(k*5 + b), 8'(255 - k - 7*b), 8'(64*b + k)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [23:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic stream(input int b);
        for (int k = 0; k < 64; k++) push(pix(b, k));
    endtask

    task automatic check_row(input int b, input int r);
        logic [63:0] ey, ecb, ecr, ry, rcb, rcr;
        logic [23:0] p;
        for (int c = 0; c < 8; c++) begin
            p = pix(b, 8*r + c);
            ry[c*8 +: 8]  = p[7:0];
            rcb[c*8 +: 8] = p[15:8];
            rcr[c*8 +: 8] = p[23:16];
            ey[c*8 +: 8]  = p[7:0] - 8'd128;
            ecb[c*8 +: 8] = p[15:8] - 8'd128;
            ecr[c*8 +: 8] = p[23:16] - 8'd128;
        end
        check($sformatf("b%0d r%0d valid", b, r), 64'(v1), 64'd1);
        check($sformatf("b%0d r%0d row", b, r), 64'(r1), 64'(r));
        check($sformatf("b%0d r%0d last", b, r), 64'(l1), 64'(r == 7));
        check($sformatf("b%0d r%0d y", b, r), y1, ey);
        check($sformatf("b%0d r%0d cb", b, r), cb1, ecb);
        check($sformatf("b%0d r%0d cr", b, r), cr1, ecr);
        check($sformatf("b%0d r%0d raw_y", b, r), y2, ry);
        check($sformatf("b%0d r%0d raw_cb", b, r), cb2, rcb);
        check($sformatf("b%0d r%0d raw_cr", b, r), cr2, rcr);
    endtask

    task automatic check_block(input int b);
        for (int r = 0; r < 8; r++) begin
            check_row(b, r);
            tick();
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " valid"}, 64'(v1), 64'd0);
        check({tag, " row"}, 64'(r1), 64'd0);
        check({tag, " last"}, 64'(l1), 64'd0);
        check({tag, " y"}, y1, 64'd0);
        check({tag, " cb"}, cb1, 64'd0);
        check({tag, " cr"}, cr1, 64'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        check_idle("reset");
        check("reset overflow", 64'(o1), 64'd0);
        rst = 1'b0;
        tick();

        // single block: first row visible right after the pixel-63 edge
        out_ready = 1'b1;
        for (int k = 0; k < 63; k++) push(pix(0, k));
        check("t1 no early valid", 64'(v1), 64'd0);
        push(pix(0, 63));
        check_block(0);
        check("t1 done valid", 64'(v1), 64'd0);

        // two stored blocks drain with no bubble
        out_ready = 1'b0;
        stream(1);
        stream(2);
        check("t2 overflow", 64'(o1), 64'd0);
        out_ready = 1'b1;
        check_block(1);
        check_block(2);
        check("t2 done valid", 64'(v1), 64'd0);

        // stall during row 3 of A; B stored, C dropped
        stream(3);
        for (int r = 0; r < 3; r++) begin
            check_row(3, r);
            tick();
        end
        out_ready = 1'b0;
        check_row(3, 3);
        stream(4);
        check("t3 ovf after B", 64'(o1), 64'd0);
        check_row(3, 3);
        for (int k = 0; k < 63; k++) push(pix(5, k));
        check("t3 ovf after C drop", 64'(o1), 64'd1);
        ovf_clr = 1'b1;
        push(pix(5, 63));
        ovf_clr = 1'b0;
        check("t3 set wins over clr", 64'(o1), 64'd1);
        repeat (72) tick();
        check_row(3, 3);
        out_ready = 1'b1;
        for (int r = 3; r < 8; r++) begin
            check_row(3, r);
            tick();
        end
        check_block(4);
        check("t3 C not stored", 64'(v1), 64'd0);
        check("t3 ovf held", 64'(o1), 64'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t3 ovf cleared", 64'(o1), 64'd0);

        // release of writer's bank coincides with pixel 0 of the next block
        out_ready = 1'b0;
        stream(6);
        stream(7);
        out_ready = 1'b1;
        for (int r = 0; r < 7; r++) begin
            check_row(6, r);
            tick();
        end
        check_row(6, 7);
        push(pix(8, 0));
        check("t4 ovf at collision", 64'(o1), 64'd0);
        fork
            for (int k = 1; k < 64; k++) push(pix(8, k));
            check_block(7);
        join
        check_block(8);
        check("t4 ovf end", 64'(o1), 64'd0);

        // asynchronous reset with a partial block written and another mid-send
        out_ready = 1'b0;
        stream(2);
        out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        check_row(2, 2);
        for (int k = 0; k <= 30; k++) push(pix(3, k));
        rst = 1'b1;
        #1;
        check_idle("t5 in reset");
        check("t5 raw valid", 64'(v2), 64'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        stream(4);
        check_block(4);
        check("t5 done valid", 64'(v1), 64'd0);

        // 0/128/255 pattern, raw build passes values unchanged
        stream(9);
        check_block(9);
        check("t6 overflow", 64'(o1), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
